systolic_feeder: RTL
====================

# systolic_feeder

Input-side feeder for the 3x3 weight-stationary systolic array. It accepts row vectors over a valid/ready handshake and stores them in a two-bank ping-pong buffer, one tile per bank. It streams each full tile into the array's top inputs with the diagonal skew the array needs: lane j is delayed j cycles, and zeros fill the unused slots. Writing one bank while the other drains gives back-to-back tiles with no bubble.

## Interface

- DW, 32, lane data width (matches array inp_up_* width)
- N, 3, number of lanes / array columns
- DEPTH, 4, vectors per tile (bank depth)

- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  producer has a vector on in_data
- in_ready  output  1  feeder can accept a vector this cycle
- in_data  input  N*DW  vector; lane j = in_data[j*DW +: DW]
- drain_en  input  1  permits starting a new tile stream
- out_data  output  N*DW  skewed lanes; lane j drives array inp_up_j
- out_valid  output  1  out_data carries stream-window data (including skew zeros)
- tile_done  output  1  one-cycle pulse coincident with the last output step of a tile
- bank_full  output  2  registered full flags of bank 0 / bank 1

## Operation

- Storage: bank[2][DEPTH][N] words of DW bits. Write-side registers: wb (write bank) and wi (write index). Read-side registers: rb (read bank) and t (step counter, 0..DEPTH+N-2). Flags: full[1:0].
- Write side:
  - in_ready = !full[wb], decoded only from registered state.
  - On accept (in_valid && in_ready): bank[wb][wi] <= in_data and wi increments.
  - When wi == DEPTH-1: full[wb] <= 1, wb toggles, wi <= 0.
- Read FSM states:
  - IDLE: out_valid = 0 and out_data = 0. If full[rb] && drain_en, go to STREAM and load step t=0 on the same edge.
  - STREAM: on each edge, load step t and advance t.
  - Step t, lane j output: bank[rb][t-j][j] if 0 <= t-j < DEPTH, else 0.
  - On the edge loading step DEPTH+N-2: tile_done is registered high, full[rb] clears, rb toggles, t resets to 0.
  - After the last step, if full[other bank] && drain_en, stay in STREAM and load step 0 of the other bank on the next edge (no gap). Otherwise go to IDLE.
- drain_en is sampled only in IDLE and at the last step. Dropping it mid-tile does not stall the current tile.
- There is no backpressure from the array. Once a tile starts it runs DEPTH+N-1 cycles uninterrupted.
- Write and read never touch the same bank: writes go only to a non-full bank and reads come only from a full bank.
- Simultaneous events:
  - The last write to one bank and the last read step of the other in the same cycle are both honoured.
  - A freed bank's in_ready rises on the cycle after its full flag clears.

## Timing

- Reset values: in_ready=1, out_data=0, out_valid=0, tile_done=0, bank_full=2'b00, wb=rb=0, wi=t=0, FSM=IDLE. Bank contents are don't-care.
- Reset mid-operation clears all state immediately. Any partial or queued tile is discarded and outputs go to 0 asynchronously.
- All outputs are registered.
- Latency:
  - Last write of a tile accepted at edge E, with drain_en=1 and the feeder idle.
  - Step 0 is visible after edge E+1; step t is visible after edge E+1+t.
  - out_valid stays high for exactly DEPTH+N-1 consecutive cycles per tile.
- Back-to-back tiles with both banks full give 2*(DEPTH+N-1) consecutive out_valid cycles.
- Throughput: one vector accepted per cycle while in_ready=1. Sustained input rate is DEPTH vectors per DEPTH+N-1 cycles.

## Test plan

Parameters for all scenarios: DW=32, N=3, DEPTH=4. Vectors are written as (lane0, lane1, lane2).

- **Reset:** assert rst with no clock -> all outputs 0, in_ready=1, bank_full=00. Release -> values unchanged until the first accept.
- **Single tile, drain_en=1:** write (1,2,3), (4,5,6), (7,8,9), (10,11,12) on consecutive cycles, then check the 6 out_valid cycles starting after the edge following the last write:
  - lane0 = 1,4,7,10,0,0
  - lane1 = 0,2,5,8,11,0
  - lane2 = 0,0,3,6,9,12
  - tile_done high only on the 6th cycle.
- **Ping-pong fill, drain_en=0:** offer 9 vectors.
  - 8 are accepted, in_ready drops after the 8th, bank_full=11, and the 9th is held.
  - Raise drain_en -> 12 consecutive out_valid cycles containing both tiles in order.
  - in_ready returns the cycle after the first tile_done, and the 9th vector is then accepted into bank 0.
- **Bubbly producer:** toggle in_valid with random gaps while writing the scenario-2 vectors -> identical output sequence, with the stream starting one edge after the 4th accept.
- **drain_en dropped mid-stream:** drop drain_en at step 2 -> the tile completes all 6 steps, and the second full bank does not start until drain_en returns high.
- **Reset mid-stream:** assert rst at step 3 -> out_data=0, out_valid=0, bank_full=00 immediately. After release, a fresh scenario-2 tile streams correctly.

Source files
------------

// File: rtl/systolic_feeder.sv
// Input-side feeder for a weight-stationary systolic array: a two-bank ping-pong tile buffer
// that streams each full tile into the array's top inputs with a per-lane diagonal skew.
module systolic_feeder #(
   parameter int unsigned DW    = 32,
   parameter int unsigned N     = 3,
   parameter int unsigned DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_data,
   input  logic            drain_en,
   output logic [N*DW-1:0] out_data,
   output logic            out_valid,
   output logic            tile_done,
   output logic [1:0]      bank_full
);

   localparam int unsigned Steps = DEPTH + N - 1;
   localparam int unsigned WiW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned TW    = $clog2(Steps);
   localparam logic [WiW-1:0] WiLast = WiW'(DEPTH - 1);
   localparam logic [TW-1:0]  TLast  = TW'(Steps - 1);

   typedef enum logic [0:0] {StIdle, StStream} state_e;

   state_e          r_state;
   state_e          w_state_d;
   logic            r_wb;
   logic [WiW-1:0]  r_wi;
   logic            r_rb;
   logic [TW-1:0]   r_t;
   logic [1:0]      r_full;
   logic [N*DW-1:0] r_out_data;
   logic            r_out_valid;
   logic            r_tile_done;

   logic            w_accept;
   logic            w_start;
   logic            w_load;
   logic            w_last;
   logic            w_chain;
   logic [1:0]      w_full_d;
   logic [N*DW-1:0] w_step_data;
   logic [N*DW-1:0] w_out_data_d;
   logic            w_out_valid_d;
   logic            w_tile_done_d;

   assign in_ready  = !r_full[r_wb];
   assign w_accept  = in_valid && in_ready;
   assign w_start   = (r_state == StIdle) && r_full[r_rb] && drain_en;
   assign w_load    = w_start || (r_state == StStream);
   assign w_last    = (r_state == StStream) && (r_t == TLast);
   assign w_chain   = r_full[~r_rb] && drain_en;

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign tile_done = r_tile_done;
   assign bank_full = r_full;

   // Each lane owns its own storage so the skewed read index stays lane-local.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [DW-1:0] r_mem [2][DEPTH];
      logic [TW:0]   w_idx;

      always_ff @(posedge clk) begin
         if (w_accept) begin
            r_mem[r_wb][r_wi] <= in_data[g*DW +: DW];
         end
      end

      // Extra top bit flags t < g, which is a leading skew zero.
      assign w_idx = {1'b0, r_t} - (TW + 1)'(g);
      assign w_step_data[g*DW +: DW] =
         (!w_idx[TW] && (w_idx < (TW + 1)'(DEPTH))) ? r_mem[r_rb][w_idx[WiW-1:0]] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StIdle:   if (w_start) w_state_d = StStream;
         StStream: if (w_last && !w_chain) w_state_d = StIdle;
         default:  w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_out_data_d  = '0;
      w_out_valid_d = 1'b0;
      w_tile_done_d = 1'b0;
      if (w_load) begin
         w_out_data_d  = w_step_data;
         w_out_valid_d = 1'b1;
         w_tile_done_d = w_last;
      end
   end

   // Set and clear can never hit the same bank: writer owns a non-full bank, reader a full one.
   always_comb begin
      w_full_d = r_full;
      if (w_accept && (r_wi == WiLast)) w_full_d[r_wb] = 1'b1;
      if (w_last) w_full_d[r_rb] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wb        <= 1'b0;
         r_wi        <= '0;
         r_rb        <= 1'b0;
         r_t         <= '0;
         r_full      <= 2'b00;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_tile_done <= 1'b0;
      end else begin
         r_full <= w_full_d;
         if (w_accept) begin
            if (r_wi == WiLast) begin
               r_wi <= '0;
               r_wb <= ~r_wb;
            end else begin
               r_wi <= r_wi + 1'b1;
            end
         end
         if (w_load) begin
            if (w_last) begin
               r_t  <= '0;
               r_rb <= ~r_rb;
            end else begin
               r_t <= r_t + 1'b1;
            end
         end
         r_out_data  <= w_out_data_d;
         r_out_valid <= w_out_valid_d;
         r_tile_done <= w_tile_done_d;
      end
   end

endmodule
